// File: rtl/alu_arbiter.sv
// alu_arbiter - shares one 8-bit ALU between two requesters with a settle-timed result capture.
// Optional: define ALU_ARB_FIXED_PRIO_EN for fixed REQ0 priority instead of round-robin.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    output logic       REQ0_READY,
    input  logic [7:0] REQ0_DATA1,
    input  logic [7:0] REQ0_DATA2,
    input  logic [2:0] REQ0_SELECT,
    input  logic       REQ1_VALID,
    output logic       REQ1_READY,
    input  logic [7:0] REQ1_DATA1,
    input  logic [7:0] REQ1_DATA2,
    input  logic [2:0] REQ1_SELECT,
    output logic       RSP0_VALID,
    output logic [7:0] RSP0_RESULT,
    output logic       RSP0_ZERO,
    output logic       RSP1_VALID,
    output logic [7:0] RSP1_RESULT,
    output logic       RSP1_ZERO,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     r_state, w_next;
    logic       r_last, r_owner;
    logic [3:0] r_cnt;
    logic [7:0] r_alu_d1, r_alu_d2, r_rsp0_res, r_rsp1_res;
    logic [2:0] r_alu_sel;
    logic       r_rsp0_zero, r_rsp1_zero;
    logic       w_gnt0, w_gnt1, w_acc;
    logic [7:0] w_d1, w_d2;
    logic [2:0] w_sel;

    // r_last holds the previous owner; the other requester wins a tie.
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_gnt0 = REQ0_VALID;
        w_gnt1 = REQ1_VALID & ~REQ0_VALID;
`else
        w_gnt0 = REQ0_VALID & (~REQ1_VALID | r_last);
        w_gnt1 = REQ1_VALID & (~REQ0_VALID | ~r_last);
`endif
        w_acc  = (r_state == IDLE) & (w_gnt0 | w_gnt1);
        w_d1   = w_gnt1 ? REQ1_DATA1  : REQ0_DATA1;
        w_d2   = w_gnt1 ? REQ1_DATA2  : REQ0_DATA2;
        w_sel  = w_gnt1 ? REQ1_SELECT : REQ0_SELECT;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = w_sel[2] ? DONE : EXEC;
            EXEC:    if (r_cnt <= 4'd1) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_cnt       <= 4'd0;
            r_alu_d1    <= 8'h00;
            r_alu_d2    <= 8'h00;
            r_alu_sel   <= 3'b000;
            r_rsp0_res  <= 8'h00;
            r_rsp0_zero <= 1'b0;
            r_rsp1_res  <= 8'h00;
            r_rsp1_zero <= 1'b0;
        end else if (w_acc) begin
            r_alu_d1  <= w_d1;
            r_alu_d2  <= w_d2;
            r_alu_sel <= w_sel;
            r_owner   <= w_gnt1;
            r_last    <= w_gnt1;
            r_cnt     <= 4'(SETTLE_CYCLES);
            // Reserved ops bypass the ALU and answer zero straight away.
            if (w_sel[2]) begin
                if (w_gnt1) begin
                    r_rsp1_res  <= 8'h00;
                    r_rsp1_zero <= 1'b1;
                end else begin
                    r_rsp0_res  <= 8'h00;
                    r_rsp0_zero <= 1'b1;
                end
            end
        end else if (r_state == EXEC) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
                if (r_owner) begin
                    r_rsp1_res  <= ALU_RESULT;
                    r_rsp1_zero <= (ALU_RESULT == 8'h00);
                end else begin
                    r_rsp0_res  <= ALU_RESULT;
                    r_rsp0_zero <= (ALU_RESULT == 8'h00);
                end
            end
        end
    end

    assign REQ0_READY  = (r_state == IDLE) & w_gnt0;
    assign REQ1_READY  = (r_state == IDLE) & w_gnt1;
    assign RSP0_VALID  = (r_state == DONE) & ~r_owner;
    assign RSP1_VALID  = (r_state == DONE) &  r_owner;
    assign RSP0_RESULT = r_rsp0_res;
    assign RSP0_ZERO   = r_rsp0_zero;
    assign RSP1_RESULT = r_rsp1_res;
    assign RSP1_ZERO   = r_rsp1_zero;
    assign ALU_DATA1   = r_alu_d1;
    assign ALU_DATA2   = r_alu_d2;
    assign ALU_SELECT  = r_alu_sel;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (SETTLE_CYCLES 1 and 3).
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1, b_v0;
    logic [7:0] a0, b0, a1, b1, b_a0, b_b0;
    logic [2:0] s0, s1, b_s0;

    logic       rdy0, rdy1, rv0, rv1, rz0, rz1;
    logic [7:0] rr0, rr1, ad1, ad2, ares;
    logic [2:0] asel;

    logic       b_rdy0, b_rdy1, b_rv0, b_rv1, b_rz0, b_rz1;
    logic [7:0] b_rr0, b_rr1, b_ad1, b_ad2, b_ares;
    logic [2:0] b_asel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [2:0] sel, input logic [7:0] x, input logic [7:0] y);
        case (sel)
            3'b000:  return y;
            3'b001:  return x + y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            default: return 8'h00;
        endcase
    endfunction

    assign ares   = alu_model(asel, ad1, ad2);
    assign b_ares = alu_model(b_asel, b_ad1, b_ad2);

    alu_arbiter #(.SETTLE_CYCLES(1)) dut (
        .CLK(clk), .RESET(rst),
        .REQ0_VALID(v0), .REQ0_READY(rdy0), .REQ0_DATA1(a0), .REQ0_DATA2(b0), .REQ0_SELECT(s0),
        .REQ1_VALID(v1), .REQ1_READY(rdy1), .REQ1_DATA1(a1), .REQ1_DATA2(b1), .REQ1_SELECT(s1),
        .RSP0_VALID(rv0), .RSP0_RESULT(rr0), .RSP0_ZERO(rz0),
        .RSP1_VALID(rv1), .RSP1_RESULT(rr1), .RSP1_ZERO(rz1),
        .ALU_DATA1(ad1), .ALU_DATA2(ad2), .ALU_SELECT(asel), .ALU_RESULT(ares)
    );

    alu_arbiter #(.SETTLE_CYCLES(3)) dut3 (
        .CLK(clk), .RESET(rst),
        .REQ0_VALID(b_v0), .REQ0_READY(b_rdy0), .REQ0_DATA1(b_a0), .REQ0_DATA2(b_b0), .REQ0_SELECT(b_s0),
        .REQ1_VALID(1'b0), .REQ1_READY(b_rdy1), .REQ1_DATA1(8'h00), .REQ1_DATA2(8'h00), .REQ1_SELECT(3'b000),
        .RSP0_VALID(b_rv0), .RSP0_RESULT(b_rr0), .RSP0_ZERO(b_rz0),
        .RSP1_VALID(b_rv1), .RSP1_RESULT(b_rr1), .RSP1_ZERO(b_rz1),
        .ALU_DATA1(b_ad1), .ALU_DATA2(b_ad2), .ALU_SELECT(b_asel), .ALU_RESULT(b_ares)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int owner;
        int exp_owner [3];
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_owner = '{0, 0, 0};
`else
        exp_owner = '{0, 1, 0};
`endif
        rst = 1'b0; v0 = 0; v1 = 0; b_v0 = 0;
        a0 = 0; b0 = 0; s0 = 0; a1 = 0; b1 = 0; s1 = 0;
        b_a0 = 0; b_b0 = 0; b_s0 = 0;
        do_reset();

        // reset state
        chk("rst_alu_d1", ad1, 8'h00);
        chk("rst_alu_sel", asel, 3'b000);
        chk("rst_rsp0_valid", rv0, 1'b0);
        chk("rst_rsp0_result", rr0, 8'h00);
        chk("rst_rsp1_zero", rz1, 1'b0);
        chk("rst_ready0_idle_novalid", rdy0, 1'b0);

        // REQ0 only: 05 + 03
        v0 = 1; a0 = 8'h05; b0 = 8'h03; s0 = 3'b001;
        #1;
        chk("t1_ready0", rdy0, 1'b1);
        chk("t1_ready1", rdy1, 1'b0);
        tick();
        v0 = 0;
        #1;
        chk("t1_alu_d1", ad1, 8'h05);
        chk("t1_alu_sel", asel, 3'b001);
        chk("t1_exec_ready0", rdy0, 1'b0);
        chk("t1_exec_rsp0_valid", rv0, 1'b0);
        tick();
        chk("t1_rsp0_valid", rv0, 1'b1);
        chk("t1_rsp0_result", rr0, 8'h08);
        chk("t1_rsp0_zero", rz0, 1'b0);
        chk("t1_rsp1_valid", rv1, 1'b0);
        chk("t1_rsp1_result", rr1, 8'h00);
        tick();
        chk("t1_rsp0_valid_drop", rv0, 1'b0);
        chk("t1_rsp0_result_hold", rr0, 8'h08);

        // both requesters valid continuously
        do_reset();
        a0 = 8'hF0; b0 = 8'h0F; s0 = 3'b010;
        a1 = 8'hF0; b1 = 8'h0F; s1 = 3'b011;
        v0 = 1; v1 = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            owner = exp_owner[k];
            chk($sformatf("t2_op%0d_ready0", k), rdy0, (owner == 0));
            chk($sformatf("t2_op%0d_ready1", k), rdy1, (owner == 1));
            tick();
            chk($sformatf("t2_op%0d_exec_ready0", k), rdy0, 1'b0);
            chk($sformatf("t2_op%0d_exec_ready1", k), rdy1, 1'b0);
            tick();
            chk($sformatf("t2_op%0d_done_ready0", k), rdy0, 1'b0);
            chk($sformatf("t2_op%0d_done_ready1", k), rdy1, 1'b0);
            if (owner == 0) begin
                chk($sformatf("t2_op%0d_rsp0_valid", k), rv0, 1'b1);
                chk($sformatf("t2_op%0d_rsp1_valid", k), rv1, 1'b0);
                chk($sformatf("t2_op%0d_rsp0_result", k), rr0, 8'h00);
                chk($sformatf("t2_op%0d_rsp0_zero", k), rz0, 1'b1);
            end else begin
                chk($sformatf("t2_op%0d_rsp1_valid", k), rv1, 1'b1);
                chk($sformatf("t2_op%0d_rsp0_valid", k), rv0, 1'b0);
                chk($sformatf("t2_op%0d_rsp1_result", k), rr1, 8'hFF);
                chk($sformatf("t2_op%0d_rsp1_zero", k), rz1, 1'b0);
            end
            tick();
        end
        v0 = 0;
        #1;
        chk("t2_ready1_after_drop", rdy1, 1'b1);
        tick();
        v1 = 0;
        tick();
        chk("t2_final_rsp1_valid", rv1, 1'b1);
        chk("t2_final_rsp1_result", rr1, 8'hFF);
        chk("t2_final_rsp1_zero", rz1, 1'b0);
        tick();

        // reserved select on REQ1
        v1 = 1; a1 = 8'h12; b1 = 8'h34; s1 = 3'b110;
        #1;
        chk("t3_ready1", rdy1, 1'b1);
        tick();
        v1 = 0;
        #1;
        chk("t3_alu_sel", asel, 3'b110);
        chk("t3_alu_d1", ad1, 8'h12);
        chk("t3_rsp1_valid", rv1, 1'b1);
        chk("t3_rsp1_result", rr1, 8'h00);
        chk("t3_rsp1_zero", rz1, 1'b1);
        tick();
        chk("t3_rsp1_valid_drop", rv1, 1'b0);

        // reset in EXEC after a REQ0 op (LAST would otherwise favour REQ1)
        v0 = 1; a0 = 8'h05; b0 = 8'h03; s0 = 3'b001;
        tick();
        v0 = 0;
        #1;
        chk("t5_in_exec_ready0", rdy0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rsp0_valid", rv0, 1'b0);
        chk("t5_alu_sel", asel, 3'b000);
        chk("t5_alu_d1", ad1, 8'h00);
        chk("t5_alu_d2", ad2, 8'h00);
        tick();
        chk("t5_rsp0_valid_after", rv0, 1'b0);
        chk("t5_rsp0_result", rr0, 8'h00);
        v0 = 1; v1 = 1;
        #1;
        chk("t5_tie_ready0", rdy0, 1'b1);
        chk("t5_tie_ready1", rdy1, 1'b0);
        v0 = 0; v1 = 0;
        tick();

        // SETTLE_CYCLES = 3 instance: pass-through of DATA2
        b_v0 = 1; b_a0 = 8'h5A; b_b0 = 8'hA5; b_s0 = 3'b000;
        #1;
        chk("t4_ready0", b_rdy0, 1'b1);
        tick();
        b_v0 = 0; b_b0 = 8'h00; b_a0 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_wait%0d_rsp0_valid", k), b_rv0, 1'b0);
            chk($sformatf("t4_wait%0d_alu_sel", k), b_asel, 3'b000);
            chk($sformatf("t4_wait%0d_alu_d2", k), b_ad2, 8'hA5);
            chk($sformatf("t4_wait%0d_alu_d1", k), b_ad1, 8'h5A);
            tick();
        end
        chk("t4_rsp0_valid", b_rv0, 1'b1);
        chk("t4_rsp0_result", b_rr0, 8'hA5);
        chk("t4_rsp0_zero", b_rz0, 1'b0);
        chk("t4_rsp1_valid", b_rv1, 1'b0);
        tick();
        chk("t4_rsp0_valid_drop", b_rv0, 1'b0);
        chk("t4_rsp0_result_hold", b_rr0, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
